// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with load, hold and auto-scan modes.
//   Parameters: N     - index width, 2**N decoded outputs (1..6)
//               DWELL - cycles each index is held while scanning (1..255)
//   Ports: clk, rst (async, active-high)
//          clr  - synchronous clear to OFF (highest priority)
//          load - capture a as the current index
//          a    - index to load
//          scan - level request to auto-advance
//          dir  - scan direction, 0 = increment, 1 = decrement
//          d    - registered one-hot of idx, all zero when OFF
//          idx  - registered current index
//          wrap - one-cycle pulse after a wrap-around advance
module scan_decoder #(
  parameter int unsigned N     = 2,
  parameter int unsigned DWELL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [N-1:0]      a,
  input  logic              scan,
  input  logic              dir,
  output logic [(1<<N)-1:0] d,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_MAX  = {N{1'b1}};

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [W-1:0]   d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wrap_q, wrap_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state: clr > load > scan advance
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;

    if (clr) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (load) begin
      idx_d   = a;
      cnt_d   = '0;
      state_d = scan ? ST_SCAN : ST_HOLD;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (!scan) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            // Dwell expired: step the index, flag a wrap-around
            cnt_d = '0;
            if (dir) begin
              idx_d  = idx_q - N'(1);
              wrap_d = (idx_q == '0);
            end else begin
              idx_d  = idx_q + N'(1);
              wrap_d = (idx_q == IDX_MAX);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          if (scan) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
          end
        end
      endcase
    end

    // Decode from the next index so d and idx change on the same edge
    d_d = (state_d == ST_OFF) ? '0 : (W'(1) << idx_d);
  end

  assign d    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Testbench for scan_decoder: two instances (N=2/DWELL=1 and N=3/DWELL=3)
// share control inputs and are checked against a behavioural model.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [2:0] a3 = 3'd0;
  logic       scan = 1'b0;
  logic       dir = 1'b0;

  logic [3:0] d2;
  logic [1:0] idx2;
  logic       wrap2;
  logic [7:0] d3;
  logic [2:0] idx3;
  logic       wrap3;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state per instance: mode 0=off 1=hold 2=scan
  int m_n[2]  = '{2, 3};
  int m_dw[2] = '{1, 3};
  int m_mode[2];
  int m_idx[2];
  int m_cnt[2];
  bit m_wrap[2];

  scan_decoder #(.N(2), .DWELL(1)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .a(a3[1:0]),
    .scan(scan), .dir(dir), .d(d2), .idx(idx2), .wrap(wrap2)
  );

  scan_decoder #(.N(3), .DWELL(3)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .a(a3),
    .scan(scan), .dir(dir), .d(d3), .idx(idx3), .wrap(wrap3)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_idx[k] = 0; m_cnt[k] = 0; m_wrap[k] = 1'b0;
    end
  endtask

  // Applies one clock edge of the block's rules to instance k
  task automatic model_step(int k);
    int sz;
    sz = 1 << m_n[k];
    m_wrap[k] = 1'b0;
    if (clr) begin
      m_mode[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
    end else if (load) begin
      m_idx[k] = int'(a3) % sz;
      m_cnt[k] = 0;
      m_mode[k] = scan ? 2 : 1;
    end else if (m_mode[k] == 2) begin
      if (!scan) begin
        m_mode[k] = 1; m_cnt[k] = 0;
      end else if (m_cnt[k] + 1 >= m_dw[k]) begin
        m_cnt[k] = 0;
        m_wrap[k] = dir ? (m_idx[k] == 0) : (m_idx[k] == sz - 1);
        m_idx[k] = dir ? (m_idx[k] + sz - 1) % sz : (m_idx[k] + 1) % sz;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end else if (scan) begin
      m_mode[k] = 2; m_cnt[k] = 0;
    end
  endtask

  function automatic logic [7:0] exp_d(int k);
    if (m_mode[k] == 0) return 8'h00;
    return 8'(1 << m_idx[k]);
  endfunction

  // One rising edge, model update, then settle to sample point
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if (d2 !== 4'b0 || idx2 !== 2'd0 || wrap2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_n2: got d=%b idx=%0d wrap=%b expected d=0000 idx=0 wrap=0", d2, idx2, wrap2);
    end
    tests_run++;
    if (d3 !== 8'b0 || idx3 !== 3'd0 || wrap3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_n3: got d=%b idx=%0d wrap=%b expected d=0 idx=0 wrap=0", d3, idx3, wrap3);
    end
    rst = 1'b0;
    model_reset();
    tick();
    tests_run++;
    if (d2 !== 4'b0 || d3 !== 8'b0) begin
      tests_failed++;
      $display("FAIL idle_off: got d2=%b d3=%b expected all zero", d2, d3);
    end
  endtask

  task automatic test_load();
    load = 1'b1; a3 = 3'b010;
    tick();
    load = 1'b0;
    tests_run++;
    if (idx2 !== 2'd2 || d2 !== 4'b0100 || wrap2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_n2: got idx=%0d d=%b wrap=%b expected idx=2 d=0100 wrap=0", idx2, d2, wrap2);
    end
    tests_run++;
    if (idx3 !== 3'd2 || d3 !== 8'b0000_0100) begin
      tests_failed++;
      $display("FAIL load_n3: got idx=%0d d=%b expected idx=2 d=00000100", idx3, d3);
    end
    // HOLD: nothing moves without scan
    tick();
    tests_run++;
    if (d2 !== 4'b0100 || d3 !== 8'b0000_0100) begin
      tests_failed++;
      $display("FAIL hold: got d2=%b d3=%b expected 0100 / 00000100", d2, d3);
    end
  endtask

  task automatic test_scan_inc();
    logic [3:0] exp_seq[4];
    logic       exp_wr[4];
    exp_seq = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_wr  = '{1'b0, 1'b0, 1'b1, 1'b0};
    scan = 1'b1; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (d2 !== exp_seq[i] || wrap2 !== exp_wr[i]) begin
        tests_failed++;
        $display("FAIL scan_inc[%0d]: got d=%b wrap=%b expected d=%b wrap=%b", i, d2, wrap2, exp_seq[i], exp_wr[i]);
      end
      tests_run++;
      if ({4'b0, d2} !== exp_d(0) || {5'b0, idx2} !== 8'(m_idx[0])) begin
        tests_failed++;
        $display("FAIL scan_inc_model[%0d]: got d=%b idx=%0d expected d=%b idx=%0d", i, d2, idx2, exp_d(0), m_idx[0]);
      end
      tests_run++;
      if (d3 !== exp_d(1) || {5'b0, idx3} !== 8'(m_idx[1]) || wrap3 !== m_wrap[1]) begin
        tests_failed++;
        $display("FAIL scan_inc_n3[%0d]: got d=%b idx=%0d wrap=%b expected d=%b idx=%0d wrap=%b", i, d3, idx3, wrap3, exp_d(1), m_idx[1], m_wrap[1]);
      end
    end
  endtask

  task automatic test_dwell_dec();
    logic [2:0] exp_idx[7];
    logic       exp_wr[7];
    exp_idx = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd6};
    exp_wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    load = 1'b1; a3 = 3'd0; scan = 1'b1; dir = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      load = 1'b0;
      tests_run++;
      if (idx3 !== exp_idx[i] || wrap3 !== exp_wr[i] || d3 !== 8'(1 << exp_idx[i])) begin
        tests_failed++;
        $display("FAIL dwell_dec[%0d]: got idx=%0d wrap=%b d=%b expected idx=%0d wrap=%b", i, idx3, wrap3, d3, exp_idx[i], exp_wr[i]);
      end
      tests_run++;
      if ({4'b0, d2} !== exp_d(0) || wrap2 !== m_wrap[0]) begin
        tests_failed++;
        $display("FAIL dwell_dec_n2[%0d]: got d=%b wrap=%b expected d=%b wrap=%b", i, d2, wrap2, exp_d(0), m_wrap[0]);
      end
    end
  endtask

  task automatic test_clr_priority();
    clr = 1'b1; load = 1'b1; scan = 1'b1; a3 = 3'd5;
    tick();
    clr = 1'b0; scan = 1'b0; a3 = 3'd1;
    tests_run++;
    if (d2 !== 4'b0 || idx2 !== 2'd0 || d3 !== 8'b0 || idx3 !== 3'd0 || wrap2 !== 1'b0 || wrap3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_priority: got d2=%b idx2=%0d d3=%b idx3=%0d expected all zero", d2, idx2, d3, idx3);
    end
    tick();
    load = 1'b0;
    tests_run++;
    if (d2 !== 4'b0010 || d3 !== 8'b0000_0010) begin
      tests_failed++;
      $display("FAIL load_after_clr: got d2=%b d3=%b expected 0010 / 00000010", d2, d3);
    end
  endtask

  task automatic test_pause();
    logic [2:0] frozen3;
    logic [1:0] frozen2;
    scan = 1'b1; dir = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    scan = 1'b0;
    tick();
    frozen2 = idx2; frozen3 = idx3;
    tick();
    tests_run++;
    if (idx2 !== frozen2 || idx3 !== frozen3 || {4'b0, d2} !== exp_d(0) || d3 !== exp_d(1)) begin
      tests_failed++;
      $display("FAIL pause: got idx2=%0d idx3=%0d expected frozen %0d %0d", idx2, idx3, frozen2, frozen3);
    end
    scan = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if ({5'b0, idx3} !== 8'(m_idx[1]) || d3 !== exp_d(1) || {6'b0, idx2} !== 8'(m_idx[0])) begin
        tests_failed++;
        $display("FAIL resume[%0d]: got idx2=%0d idx3=%0d expected %0d %0d", i, idx2, idx3, m_idx[0], m_idx[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; a3 = 3'd3; scan = 1'b1; dir = 1'b0;
    tick();
    load = 1'b0;
    tests_run++;
    if (idx2 !== 2'd3 || d2 !== 4'b1000) begin
      tests_failed++;
      $display("FAIL pre_reset: got idx=%0d d=%b expected idx=3 d=1000", idx2, d2);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (d2 !== 4'b0 || idx2 !== 2'd0 || wrap2 !== 1'b0 || d3 !== 8'b0 || idx3 !== 3'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got d2=%b idx2=%0d wrap2=%b d3=%b expected zeros", d2, idx2, wrap2, d3);
    end
    model_reset();
    rst = 1'b0;
    scan = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (d2 !== 4'b0 || d3 !== 8'b0 || wrap2 !== 1'b0) begin
        tests_failed++;
        $display("FAIL stay_off[%0d]: got d2=%b d3=%b expected zeros", i, d2, d3);
      end
    end
    scan = 1'b1;
    tick();
    tests_run++;
    if (d2 !== 4'b0001 || d3 !== 8'b0000_0001) begin
      tests_failed++;
      $display("FAIL scan_from_off: got d2=%b d3=%b expected 0001 / 00000001", d2, d3);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(31) == 0);
      load = ($urandom_range(7) == 0);
      scan = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) dir = ~dir;
      a3   = 3'($urandom);
      tick();
      tests_run++;
      if ({4'b0, d2} !== exp_d(0) || {6'b0, idx2} !== 8'(m_idx[0]) || wrap2 !== m_wrap[0]) begin
        tests_failed++;
        $display("FAIL rand_n2[%0d]: got d=%b idx=%0d wrap=%b expected d=%b idx=%0d wrap=%b", i, d2, idx2, wrap2, exp_d(0), m_idx[0], m_wrap[0]);
      end
      tests_run++;
      if (d3 !== exp_d(1) || {5'b0, idx3} !== 8'(m_idx[1]) || wrap3 !== m_wrap[1]) begin
        tests_failed++;
        $display("FAIL rand_n3[%0d]: got d=%b idx=%0d wrap=%b expected d=%b idx=%0d wrap=%b", i, d3, idx3, wrap3, exp_d(1), m_idx[1], m_wrap[1]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_scan_inc();
    test_dwell_dec();
    test_clr_priority();
    test_pause();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
